// File: rtl/iob_uart16550_ctrl_pkg.sv
// Shared constants for the iob_uart16550 sequencer: UART register byte addresses,
// LSR bit positions, init values and the controller FSM encoding.
package iob_uart16550_ctrl_pkg;

  // UART register byte addresses (DLAB selects DLL/DLM over RBR/THR/IER)
  localparam logic [7:0] ADDR_RBR = 8'd0;
  localparam logic [7:0] ADDR_THR = 8'd0;
  localparam logic [7:0] ADDR_DLL = 8'd0;
  localparam logic [7:0] ADDR_IER = 8'd1;
  localparam logic [7:0] ADDR_DLM = 8'd1;
  localparam logic [7:0] ADDR_FCR = 8'd2;
  localparam logic [7:0] ADDR_LCR = 8'd3;
  localparam logic [7:0] ADDR_LSR = 8'd5;

  // LSR bit indices
  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_OE   = 1;
  localparam int unsigned LSR_BI   = 4;
  localparam int unsigned LSR_THRE = 5;

  localparam logic [7:0] FCR_INIT = 8'h07;
  localparam logic [7:0] LCR_DLAB = 8'h80;

  typedef enum logic [3:0] {
    StInitLcrDlab,
    StInitDll,
    StInitDlm,
    StInitLcr,
    StInitFcr,
    StInitIer,
    StIdle,
    StLsrRd,
    StLsrWait,
    StThrWr,
    StRbrRd,
    StRbrWait
  } state_e;

endpackage

// File: rtl/iob_uart16550_ctrl_busif.sv
// Single-request iob master. A start pulse captures one request, which is held on the
// bus until accepted; writes finish on acceptance, reads finish on rvalid.
// Ports: clk_i/cke_i/arst_i; start_i, we_i, addr_i, wbyte_i (request); accept_o (request
// accepted this cycle), done_o (transaction complete), rdata_byte_o (addressed read byte);
// iob_* toward the UART slave.
module iob_uart16550_ctrl_busif #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [7:0]          wbyte_i,
  output logic                accept_o,
  output logic                done_o,
  output logic [7:0]          rdata_byte_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i
);

  localparam int unsigned NLanes = DATA_W / 8;
  localparam int unsigned LaneW  = $clog2(NLanes);

  logic                avalid_q, avalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NLanes-1:0]   wstrb_q, wstrb_d;
  logic                we_q, we_d;
  logic                wait_q, wait_d;
  logic                rdone;

  assign accept_o = cke_i & avalid_q & iob_ready_i;
  assign rdone    = cke_i & wait_q & iob_rvalid_i;
  assign done_o   = (accept_o & we_q) | rdone;

  assign rdata_byte_o = iob_rdata_i[{addr_q[LaneW-1:0], 3'b000} +: 8];

  always_comb begin
    avalid_d = avalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    we_d     = we_q;
    wait_d   = wait_q;
    if (cke_i) begin
      if (accept_o) begin
        avalid_d = 1'b0;
        wait_d   = ~we_q;
      end
      if (rdone) wait_d = 1'b0;
      if (start_i) begin
        avalid_d = 1'b1;
        addr_d   = addr_i;
        wdata_d  = {NLanes{wbyte_i}};
        wstrb_d  = '0;
        wstrb_d[addr_i[LaneW-1:0]] = we_i;
        we_d     = we_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      wait_q   <= wait_d;
    end
  end

  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// Autonomous sequencer in front of one iob_uart16550. Programs divisor, LCR, FCR and
// IER, then round-robins the register port between a TX byte stream (THR bursts gated
// by LSR.THRE) and an RX byte stream (RBR reads gated by LSR.DR), collecting sticky
// LSR error bits.
// Ports: clk_i/cke_i/arst_i; cfg_use_i/div_i/lcr_i/restart_i (configuration);
// init_done_o; tx_* (byte sink, valid/ready); rx_* (byte source, valid/ready);
// err_o/err_clr_i (sticky BI,FE,PE,OE); iob_* master port toward the UART.
module iob_uart16550_ctrl
  import iob_uart16550_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TX_BURST = 16,
  parameter logic [15:0] DIV_RST  = 16'd2,
  parameter logic [7:0]  LCR_RST  = 8'h1B
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                cfg_use_i,
  input  logic [15:0]         div_i,
  input  logic [7:0]          lcr_i,
  input  logic                restart_i,
  output logic                init_done_o,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic [3:0]          err_o,
  input  logic                err_clr_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i
);

  localparam int unsigned BurstW = $clog2(TX_BURST + 1);

  state_e            state_q, state_d;
  logic              issued_q, issued_d;    // request for the current state already started
  logic [BurstW-1:0] burst_q, burst_d;
  logic              rr_q, rr_d;            // 1: RX has priority on a tie
  logic              serve_rx_q, serve_rx_d;
  logic [15:0]       div_q, div_d;
  logic [7:0]        lcr_q, lcr_d;
  logic              init_done_q, init_done_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [3:0]        err_q, err_d;
  logic              restart_q, restart_d;

  logic              req_state, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_byte;
  logic              bus_start, bus_accept, bus_done;
  logic [7:0]        rbyte;
  logic [15:0]       div_sel;
  logic [7:0]        lcr_sel;
  logic [BurstW-1:0] burst_inc;
  logic              go_init, serve_rx_sel;

  assign div_sel   = cfg_use_i ? div_i : DIV_RST;
  assign lcr_sel   = cfg_use_i ? lcr_i : LCR_RST;
  assign burst_inc = burst_q + BurstW'(1);

  // Request issued by each bus state
  always_comb begin
    req_state = 1'b1;
    req_we    = 1'b1;
    req_addr  = '0;
    req_byte  = 8'h00;
    unique case (state_q)
      StInitLcrDlab: begin req_addr = ADDR_W'(ADDR_LCR); req_byte = LCR_DLAB | lcr_sel; end
      StInitDll:     begin req_addr = ADDR_W'(ADDR_DLL); req_byte = div_q[7:0];         end
      StInitDlm:     begin req_addr = ADDR_W'(ADDR_DLM); req_byte = div_q[15:8];        end
      StInitLcr:     begin req_addr = ADDR_W'(ADDR_LCR); req_byte = lcr_q & 8'h7F;      end
      StInitFcr:     begin req_addr = ADDR_W'(ADDR_FCR); req_byte = FCR_INIT;           end
      StInitIer:     begin req_addr = ADDR_W'(ADDR_IER); req_byte = 8'h00;              end
      StLsrRd:       begin req_addr = ADDR_W'(ADDR_LSR); req_we = 1'b0;                 end
      StThrWr:       begin req_addr = ADDR_W'(ADDR_THR); req_byte = tx_data_i;          end
      StRbrRd:       begin req_addr = ADDR_W'(ADDR_RBR); req_we = 1'b0;                 end
      default:       begin req_state = 1'b0; req_we = 1'b0;                             end
    endcase
  end

  // A THR write is only started while a byte is actually offered
  assign bus_start = cke_i & req_state & ~issued_q & ~((state_q == StThrWr) & ~tx_valid_i);

  iob_uart16550_ctrl_busif #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_busif (
    .clk_i        (clk_i),
    .cke_i        (cke_i),
    .arst_i       (arst_i),
    .start_i      (bus_start),
    .we_i         (req_we),
    .addr_i       (req_addr),
    .wbyte_i      (req_byte),
    .accept_o     (bus_accept),
    .done_o       (bus_done),
    .rdata_byte_o (rbyte),
    .iob_avalid_o (iob_avalid_o),
    .iob_addr_o   (iob_addr_o),
    .iob_wdata_o  (iob_wdata_o),
    .iob_wstrb_o  (iob_wstrb_o),
    .iob_rvalid_i (iob_rvalid_i),
    .iob_rdata_i  (iob_rdata_i),
    .iob_ready_i  (iob_ready_i)
  );

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    burst_d      = burst_q;
    rr_d         = rr_q;
    serve_rx_d   = serve_rx_q;
    div_d        = div_q;
    lcr_d        = lcr_q;
    init_done_d  = init_done_q;
    rx_valid_d   = rx_valid_q;
    rx_data_d    = rx_data_q;
    err_d        = err_q;
    restart_d    = restart_q;
    go_init      = 1'b0;
    serve_rx_sel = 1'b0;
    if (cke_i) begin
      issued_d = (issued_q & ~bus_accept) | bus_start;
      if (err_clr_i) err_d = '0;
      if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
      unique case (state_q)
        StInitLcrDlab: begin
          if (bus_start) begin
            div_d = div_sel;
            lcr_d = lcr_sel;
          end
          if (bus_done) state_d = StInitDll;
        end
        StInitDll: if (bus_done) state_d = StInitDlm;
        StInitDlm: if (bus_done) state_d = StInitLcr;
        StInitLcr: if (bus_done) state_d = StInitFcr;
        StInitFcr: if (bus_done) state_d = StInitIer;
        StInitIer: begin
          if (bus_done) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end
        end
        StIdle: begin
          if (restart_q) begin
            go_init = 1'b1;
          end else if (tx_valid_i || !rx_valid_q) begin
            serve_rx_sel = (tx_valid_i && !rx_valid_q) ? rr_q : ~tx_valid_i;
            serve_rx_d   = serve_rx_sel;
            rr_d         = ~serve_rx_sel;
            state_d      = StLsrRd;
          end
        end
        StLsrRd: if (bus_accept) state_d = StLsrWait;
        StLsrWait: begin
          if (bus_done) begin
            // OR after the clear above so a coincident new error survives err_clr_i
            err_d = err_d | rbyte[LSR_BI:LSR_OE];
            if (restart_q) begin
              go_init = 1'b1;
            end else if (!serve_rx_q && rbyte[LSR_THRE]) begin
              state_d = StThrWr;
              burst_d = '0;
            end else if (serve_rx_q && rbyte[LSR_DR]) begin
              state_d = StRbrRd;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StThrWr: begin
          if (!issued_q && !tx_valid_i) begin
            if (restart_q) go_init = 1'b1;
            else           state_d = StIdle;
          end else if (bus_done) begin
            burst_d = burst_inc;
            if (restart_q)                          go_init = 1'b1;
            else if (burst_inc >= BurstW'(TX_BURST)) state_d = StIdle;
          end
        end
        StRbrRd: if (bus_accept) state_d = StRbrWait;
        StRbrWait: begin
          if (bus_done) begin
            rx_data_d  = rbyte;
            rx_valid_d = 1'b1;
            if (restart_q) go_init = 1'b1;
            else           state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      if (go_init) begin
        state_d     = StInitLcrDlab;
        init_done_d = 1'b0;
      end
      restart_d = restart_i | (restart_q & ~go_init);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StInitLcrDlab;
      issued_q    <= 1'b0;
      burst_q     <= '0;
      rr_q        <= 1'b0;
      serve_rx_q  <= 1'b0;
      div_q       <= '0;
      lcr_q       <= '0;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      err_q       <= '0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      burst_q     <= burst_d;
      rr_q        <= rr_d;
      serve_rx_q  <= serve_rx_d;
      div_q       <= div_d;
      lcr_q       <= lcr_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      err_q       <= err_d;
      restart_q   <= restart_d;
    end
  end

  // Pulses exactly in the cycle the THR write is accepted
  assign tx_ready_o  = (state_q == StThrWr) & bus_accept;
  assign init_done_o = init_done_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign err_o       = err_q;

endmodule
